// File: rtl/gpio_arb_pkg.sv
// Shared types and register map for the GPIO port arbiter.
package gpio_arb_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, CLR, RESP} state_t;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_DIR   = 2'd1;
  localparam logic [1:0] ADDR_IMASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT  = 2'd3;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Round-robin one-hot pick among NREQ requesters; last_gnt advances only on update.
module gpio_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    update,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int IDXW = $clog2(NREQ);

  logic [IDXW-1:0] last_gnt_reg;
  logic            found;

  // Two passes: requesters above last_gnt first, then wrap around from index 0.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (IDXW'(j) > last_gnt_reg)) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (IDXW'(j) <= last_gnt_reg)) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_reg <= IDXW'(NREQ - 1);
    end else if (update) begin
      last_gnt_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/gpio_port_arbiter.sv
// Shares the 4-register GPIO port slave between NREQ requesters, one single-beat access at a time.
// Define GPIO_ARB_IRQ_SVC_EN to enable autonomous edge-capture interrupt servicing.
module gpio_port_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [2*NREQ-1:0] req_addr,
  input  logic [4*NREQ-1:0] req_be,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              irq,
  output logic [31:0]       irq_capture,
  output logic              irq_event
);

  localparam int IDXW = $clog2(NREQ);

  state_t            state_reg;
  logic              we_reg;
  logic              svc_reg;
  logic [NREQ-1:0]   gnt_reg;

  logic [1:0]        addr_arr  [NREQ];
  logic [3:0]        be_arr    [NREQ];
  logic [31:0]       wdata_arr [NREQ];

  logic [NREQ-1:0]   gnt;
  logic [IDXW-1:0]   gnt_idx;
  logic              start_svc;
  logic              start_req;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr[2*gi +: 2];
    assign be_arr[gi]    = req_be[4*gi +: 4];
    assign wdata_arr[gi] = req_wdata[32*gi +: 32];
  end

`ifdef GPIO_ARB_IRQ_SVC_EN
  logic        fair_reg;
  logic [31:0] capt_shadow_reg;

  // After a service, a pending requester goes first so irq cannot starve the bus.
  assign start_svc = (state_reg == IDLE) && irq && !(fair_reg && (|req));
`else
  logic unused_irq;

  assign unused_irq  = irq;
  assign start_svc   = 1'b0;
  assign irq_capture = '0;
  assign irq_event   = 1'b0;
`endif

  assign start_req = (state_reg == IDLE) && (|req) && !start_svc;

  gpio_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .update  (start_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      svc_reg        <= 1'b0;
      gnt_reg        <= '0;
      done           <= '0;
      rsp_rdata      <= '0;
      avm_address    <= ADDR_DATA;
      avm_byteenable <= '0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
`ifdef GPIO_ARB_IRQ_SVC_EN
      fair_reg        <= 1'b0;
      capt_shadow_reg <= '0;
      irq_capture     <= '0;
      irq_event       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_svc) begin
            svc_reg        <= 1'b1;
            we_reg         <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_read       <= 1'b1;
            avm_address    <= ADDR_CAPT;
            avm_byteenable <= BE_ALL;
            avm_writedata  <= '0;
            state_reg      <= ISSUE;
          end else if (start_req) begin
            svc_reg        <= 1'b0;
            we_reg         <= req_we[gnt_idx];
            gnt_reg        <= gnt;
            avm_chipselect <= 1'b1;
            avm_read       <= !req_we[gnt_idx];
            avm_write      <= req_we[gnt_idx];
            avm_address    <= addr_arr[gnt_idx];
            avm_byteenable <= be_arr[gnt_idx];
            avm_writedata  <= wdata_arr[gnt_idx];
`ifdef GPIO_ARB_IRQ_SVC_EN
            fair_reg       <= 1'b0;
`endif
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          avm_chipselect <= 1'b0;
          avm_read       <= 1'b0;
          avm_write      <= 1'b0;
          avm_address    <= ADDR_DATA;
          avm_byteenable <= '0;
          avm_writedata  <= '0;
          if (we_reg) begin
            done      <= gnt_reg;
            state_reg <= RESP;
          end else begin
            state_reg <= CAPT;
          end
        end
        CAPT: begin
`ifdef GPIO_ARB_IRQ_SVC_EN
          if (svc_reg) begin
            capt_shadow_reg <= avm_readdata;
            avm_chipselect  <= 1'b1;
            avm_write       <= 1'b1;
            avm_address     <= ADDR_CAPT;
            avm_byteenable  <= BE_ALL;
            avm_writedata   <= '0;
            state_reg       <= CLR;
          end else
`endif
          begin
            rsp_rdata <= avm_readdata;
            done      <= gnt_reg;
            state_reg <= RESP;
          end
        end
`ifdef GPIO_ARB_IRQ_SVC_EN
        CLR: begin
          avm_chipselect <= 1'b0;
          avm_write      <= 1'b0;
          avm_address    <= ADDR_DATA;
          avm_byteenable <= '0;
          irq_capture    <= capt_shadow_reg;
          irq_event      <= 1'b1;
          fair_reg       <= 1'b1;
          state_reg      <= RESP;
        end
`endif
        RESP: begin
          done      <= '0;
`ifdef GPIO_ARB_IRQ_SVC_EN
          irq_event <= 1'b0;
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_port_arbiter.sv
// Directed self-checking bench for gpio_port_arbiter with a small GPIO port model.
// Build with GPIO_ARB_IRQ_SVC_EN defined to exercise the interrupt service path.
module tb_gpio_port_arbiter;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_we;
  logic [2*NREQ-1:0] req_addr;
  logic [4*NREQ-1:0] req_be;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   done;
  logic [31:0]       rsp_rdata;
  logic [1:0]        avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              irq;
  logic [31:0]       irq_capture;
  logic              irq_event;

  logic [31:0] rd_value;
  logic [31:0] edge_in;
  logic [31:0] capt_q;
  logic        port_irq;
  logic        irq_force;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_port_arbiter #(.NREQ(NREQ)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_be         (req_be),
    .req_wdata      (req_wdata),
    .done           (done),
    .rsp_rdata      (rsp_rdata),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .irq            (irq),
    .irq_capture    (irq_capture),
    .irq_event      (irq_event)
  );

  // Port model: registered readdata, edge-capture register cleared by a write, irq re-registered.
  always @(posedge clk) begin
    if (reset) begin
      capt_q       <= '0;
      port_irq     <= 1'b0;
      avm_readdata <= '0;
    end else begin
      if (avm_chipselect && avm_read)
        avm_readdata <= (avm_address == 2'd3) ? capt_q : rd_value;
      if (avm_chipselect && avm_write && avm_address == 2'd3)
        capt_q <= avm_writedata;
      else
        capt_q <= capt_q | edge_in;
      port_irq <= |capt_q;
    end
  end

  assign irq = port_irq | irq_force;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int j, input logic we, input logic [1:0] addr,
                         input logic [31:0] wdata);
    req_we[j]              = we;
    req_addr[2*j +: 2]     = addr;
    req_be[4*j +: 4]       = 4'hF;
    req_wdata[32*j +: 32]  = wdata;
  endtask

  logic [NREQ-1:0] alt_exp [4];

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    rd_value  = '0;
    edge_in   = '0;
    irq_force = 1'b0;
    alt_exp[0] = 2'b01;
    alt_exp[1] = 2'b10;
    alt_exp[2] = 2'b01;
    alt_exp[3] = 2'b10;
    repeat (3) step();
    reset = 1'b0;

    check("rst_cs",    32'(avm_chipselect), 32'd0);
    check("rst_read",  32'(avm_read),       32'd0);
    check("rst_write", 32'(avm_write),      32'd0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_rdata", rsp_rdata,           32'd0);
    check("rst_icap",  irq_capture,         32'd0);
    check("rst_ievt",  32'(irq_event),      32'd0);

    // Write from req0
    set_req(0, 1'b1, 2'd1, 32'h0000_00FF);
    req[0] = 1'b1;
    step();
    check("wr_cs",    32'(avm_chipselect), 32'd1);
    check("wr_write", 32'(avm_write),      32'd1);
    check("wr_read",  32'(avm_read),       32'd0);
    check("wr_addr",  32'(avm_address),    32'd1);
    check("wr_data",  avm_writedata,       32'h0000_00FF);
    check("wr_be",    32'(avm_byteenable), 32'hF);
    step();
    check("wr_done",  32'(done),           32'b01);
    check("wr_cs_off", 32'(avm_chipselect), 32'd0);
    req[0] = 1'b0;
    $display("txn write req0 addr 1 done=%b", done);
    step();
    check("wr_done_off", 32'(done), 32'd0);

    // Read from req1
    rd_value = 32'hA5A5_0001;
    set_req(1, 1'b0, 2'd0, 32'h0);
    req[1] = 1'b1;
    step();
    check("rd_cs",   32'(avm_chipselect), 32'd1);
    check("rd_read", 32'(avm_read),       32'd1);
    check("rd_addr", 32'(avm_address),    32'd0);
    step();
    check("rd_done_early", 32'(done), 32'd0);
    step();
    check("rd_done",  32'(done), 32'b10);
    check("rd_rdata", rsp_rdata, 32'hA5A5_0001);
    req[1] = 1'b0;
    $display("txn read req1 addr 0 rdata=%h", rsp_rdata);
    step();

    // Both requesters held: grants must alternate
    set_req(0, 1'b1, 2'd2, 32'h1111_0000);
    set_req(1, 1'b1, 2'd1, 32'h2222_0000);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = 0;
      do begin
        step();
        k++;
      end while (done == '0 && k < 8);
      check("alt_gnt", 32'(done), 32'(alt_exp[i]));
      $display("txn alternating grant %0d done=%b", i, done);
    end
    req = '0;
    step();

    // Reset during CAPT of a read
    rd_value = 32'h1234_5678;
    set_req(1, 1'b0, 2'd0, 32'h0);
    req[1] = 1'b1;
    step();
    check("rr_read", 32'(avm_read), 32'd1);
    step();
    reset = 1'b1;
    set_req(0, 1'b1, 2'd2, 32'h0000_0055);
    req[0] = 1'b1;
    step();
    reset = 1'b0;
    check("rr_cs",    32'(avm_chipselect), 32'd0);
    check("rr_rd",    32'(avm_read),       32'd0);
    check("rr_wr",    32'(avm_write),      32'd0);
    check("rr_done",  32'(done),           32'd0);
    step();
    check("rr_next_addr",  32'(avm_address), 32'd2);
    check("rr_next_write", 32'(avm_write),   32'd1);
    step();
    check("rr_next_done", 32'(done), 32'b01);
    $display("txn reset abort then req0 done=%b", done);
    req = '0;
    step();

`ifdef GPIO_ARB_IRQ_SVC_EN
    // Interrupt service with capture 0x4
    edge_in = 32'h0000_0004;
    step();
    edge_in = '0;
    step();
    step();
    check("irq_read", 32'(avm_read),    32'd1);
    check("irq_raddr", 32'(avm_address), 32'd3);
    step();
    check("irq_capt_cs", 32'(avm_chipselect), 32'd0);
    step();
    check("irq_clr_wr",   32'(avm_write),      32'd1);
    check("irq_clr_addr", 32'(avm_address),    32'd3);
    check("irq_clr_data", avm_writedata,       32'd0);
    check("irq_clr_be",   32'(avm_byteenable), 32'hF);
    step();
    check("irq_evt",  32'(irq_event), 32'd1);
    check("irq_capv", irq_capture,    32'h0000_0004);
    $display("txn irq service capture=%h", irq_capture);

    // irq re-asserts at once while req0 pends: req0 must win first
    set_req(0, 1'b1, 2'd1, 32'h0000_00AA);
    req[0]    = 1'b1;
    irq_force = 1'b1;
    step();
    check("fair_evt_off", 32'(irq_event), 32'd0);
    step();
    check("fair_req_wr",   32'(avm_write),   32'd1);
    check("fair_req_addr", 32'(avm_address), 32'd1);
    step();
    check("fair_req_done", 32'(done), 32'b01);
    req[0] = 1'b0;
    step();
    step();
    check("fair_irq_read", 32'(avm_read),    32'd1);
    check("fair_irq_addr", 32'(avm_address), 32'd3);
    irq_force = 1'b0;
    begin
      int k;
      k = 0;
      do begin
        step();
        k++;
      end while (!irq_event && k < 8);
      check("fair_irq_evt", 32'(irq_event), 32'd1);
    end
    $display("txn second irq service capture=%h", irq_capture);
    step();
`else
    // Without the service option irq must not start a bus cycle
    irq_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("irq_ignored_cs", 32'(avm_chipselect), 32'd0);
    end
    check("irq_ignored_cap", irq_capture, 32'd0);
    irq_force = 1'b0;
    $display("txn irq ignored");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
